// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift unit.
//   shift_mode_e : operation select (SLL/SRL/SRA/ROR), matches the mode port
//   seq_state_e  : sequencer FSM states
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift sequencer: shifts data by 0..STEP_MAX positions.
// Purely combinational log2 mux tree; stage i conditionally shifts by 2**i.
// Ports:
//   data   in  WIDTH   operand
//   mode   in  2       SLL/SRL/SRA/ROR
//   step   in  STEP_W  shift distance for this iteration (<= STEP_MAX)
//   result out WIDTH   shifted value
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP_MAX = 4,
    parameter int STEP_W   = $clog2(STEP_MAX + 1)
) (
    input  logic [WIDTH-1:0]  data,
    input  shift_mode_e       mode,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  result
);

    logic [WIDTH-1:0] stage [STEP_W+1];

    assign stage[0] = data;

    for (genvar i = 0; i < STEP_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        logic [WIDTH-1:0] shifted;

        // SRA fills with this stage's own MSB; every stage preserves the
        // sign bit, so this equals the original operand's sign.
        always_comb begin
            unique case (mode)
                SH_SLL:  shifted = stage[i] << SH;
                SH_SRL:  shifted = stage[i] >> SH;
                SH_SRA:  shifted = WIDTH'($signed(stage[i]) >>> SH);
                default: shifted = (stage[i] >> SH) | (stage[i] << (WIDTH - SH));
            endcase
        end

        assign stage[i+1] = step[i] ? shifted : stage[i];
    end

    assign result = stage[STEP_W];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter (SLL/SRL/SRA/ROR) that walks the shift amount
// down by at most STEP_MAX positions per cycle instead of using a full
// barrel shifter. start/busy/done handshake; result held until next accept.
// Ports:
//   clk          in  1      clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      request, only sampled in IDLE
//   mode         in  2      00 SLL, 01 SRL, 10 SRA, 11 ROR (latched at accept)
//   data_in      in  WIDTH  operand (latched at accept)
//   shift_amount in  AMT_W  shift distance (latched at accept)
//   busy         out 1      high whenever not IDLE
//   done         out 1      one-cycle pulse, result valid in the same cycle
//   result       out WIDTH  registered result
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP_MAX = 4,
    parameter int AMT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int STEP_W = $clog2(STEP_MAX + 1);

    seq_state_e        state;
    shift_mode_e       mode_reg;
    logic [WIDTH-1:0]  data_reg;
    logic [AMT_W-1:0]  rem;

    logic [STEP_W-1:0] step;
    logic [AMT_W-1:0]  rem_next;
    logic [WIDTH-1:0]  shifted;

    // step = min(rem, STEP_MAX); step never exceeds rem so rem cannot wrap.
    always_comb begin
        step = STEP_W'(STEP_MAX);
        if (rem < AMT_W'(STEP_MAX))
            step = STEP_W'(rem);
        rem_next = rem - AMT_W'(step);
    end

    shift_step #(
        .WIDTH    (WIDTH),
        .STEP_MAX (STEP_MAX),
        .STEP_W   (STEP_W)
    ) u_step (
        .data   (data_reg),
        .mode   (mode_reg),
        .step   (step),
        .result (shifted)
    );

    // result is loaded on the edge that enters DONE, so it lines up with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            data_reg <= '0;
            rem      <= '0;
            mode_reg <= SH_SLL;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        data_reg <= data_in;
                        mode_reg <= shift_mode_e'(mode);
                        rem      <= shift_amount;
                        busy     <= 1'b1;
                        if (shift_amount == '0) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= data_in;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_reg <= shifted;
                    rem      <= rem_next;
                    if (rem_next == '0) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= shifted;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
